spi_slave_if: RTL

SPI mode-0 target (responder) that lets the SoC act as a peripheral on an external SPI bus, the opposite end of the SoC's SPI master port (spi_clk, spi_mosi, spi_miso, spi_cs). All SPI inputs are oversampled and synchronised into the system clock domain. Received bytes are delivered as single-cycle strobes. Transmit bytes are supplied through a one-deep holding register with a valid/ready handshake, so the CPU or a DMA can feed back-to-back bytes.

---
 rtl/spi_slave_if.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_if.sv
// SPI mode-0 target: oversampled, synchronised SPI pins, byte receive strobes and
// a one-deep transmit holding register with valid/ready handshake.
module spi_slave_if #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_clk,
   input  logic       spi_cs,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_underrun,
   output logic       active
);

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_reg;
   logic [SYNC_STAGES-1:0] cs_sync_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;
   logic                   sclk_prev_reg;
   logic                   cs_prev_reg;
   logic                   sclk_rise_reg;
   logic                   sclk_fall_reg;
   logic                   cs_fall_reg;
   logic                   cs_rise_reg;

   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;

   state_t                 state_reg;
   logic [2:0]             bit_cnt_reg;
   logic [7:0]             shift_rx_reg;
   logic [7:0]             shift_tx_reg;
   logic [7:0]             hold_reg;
   logic                   hold_full_reg;
   logic                   load_pending_reg;
   logic [7:0]             rx_data_reg;
   logic                   rx_valid_reg;
   logic                   tx_underrun_reg;

   logic                   tx_wr;
   logic                   load;

   assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
   assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

   // The cs chain resets to the asserted level so that a transaction still running
   // when reset is released never produces a cs_fall; only a fresh high-to-low does.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_reg <= '0;
         cs_sync_reg   <= '0;
         mosi_sync_reg <= '0;
         sclk_prev_reg <= 1'b0;
         cs_prev_reg   <= 1'b0;
         sclk_rise_reg <= 1'b0;
         sclk_fall_reg <= 1'b0;
         cs_fall_reg   <= 1'b0;
         cs_rise_reg   <= 1'b0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev_reg <= sclk_s;
         cs_prev_reg   <= cs_s;
         sclk_rise_reg <= sclk_s & ~sclk_prev_reg;
         sclk_fall_reg <= ~sclk_s & sclk_prev_reg;
         cs_fall_reg   <= ~cs_s & cs_prev_reg;
         cs_rise_reg   <= cs_s & ~cs_prev_reg;
      end
   end

   assign tx_wr = tx_valid & ~hold_full_reg;
   assign load  = ((state_reg == IDLE) && cs_fall_reg) ||
                  ((state_reg == SHIFT) && !cs_rise_reg && sclk_fall_reg && load_pending_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         bit_cnt_reg      <= 3'd0;
         shift_rx_reg     <= 8'h00;
         shift_tx_reg     <= IDLE_BYTE;
         hold_reg         <= 8'h00;
         hold_full_reg    <= 1'b0;
         load_pending_reg <= 1'b0;
         rx_data_reg      <= 8'h00;
         rx_valid_reg     <= 1'b0;
         tx_underrun_reg  <= 1'b0;
      end else begin
         rx_valid_reg    <= 1'b0;
         tx_underrun_reg <= 1'b0;

         if (tx_wr) begin
            hold_reg      <= tx_data;
            hold_full_reg <= 1'b1;
         end

         // A write landing in the same cycle as a load only reaches the next load.
         if (load) begin
            if (hold_full_reg) begin
               shift_tx_reg  <= hold_reg;
               hold_full_reg <= 1'b0;
            end else begin
               shift_tx_reg    <= IDLE_BYTE;
               tx_underrun_reg <= 1'b1;
            end
         end

         case (state_reg)
            IDLE: begin
               if (cs_fall_reg) begin
                  state_reg        <= SHIFT;
                  bit_cnt_reg      <= 3'd0;
                  load_pending_reg <= 1'b0;
               end
            end
            SHIFT: begin
               if (cs_rise_reg) begin
                  state_reg        <= IDLE;
                  bit_cnt_reg      <= 3'd0;
                  load_pending_reg <= 1'b0;
               end else begin
                  if (sclk_rise_reg) begin
                     shift_rx_reg <= {shift_rx_reg[6:0], mosi_s};
                     bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                     if (bit_cnt_reg == 3'd7) begin
                        rx_data_reg      <= {shift_rx_reg[6:0], mosi_s};
                        rx_valid_reg     <= 1'b1;
                        load_pending_reg <= 1'b1;
                     end
                  end
                  if (sclk_fall_reg) begin
                     if (load_pending_reg) begin
                        load_pending_reg <= 1'b0;
                     end else begin
                        shift_tx_reg <= {shift_tx_reg[6:0], 1'b0};
                     end
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign spi_miso    = (state_reg == SHIFT) ? shift_tx_reg[7] : 1'b1;
   assign active      = (state_reg == SHIFT);
   assign tx_ready    = ~hold_full_reg;
   assign rx_data     = rx_data_reg;
   assign rx_valid    = rx_valid_reg;
   assign tx_underrun = tx_underrun_reg;

endmodule
